// File: rtl/ddr_rx_pkg.sv
// Shared types and helpers for the DDR receive deserializer.
// Holds the aligner state encoding and the match-counter width function.
package ddr_rx_pkg;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } ddr_rx_state_t;

    function automatic int cnt_width(input int lock_count);
        return $clog2(lock_count + 1);
    endfunction

endpackage

// File: rtl/ddr_rx_fifo.sv
// Show-ahead synchronous FIFO with flush for aligned receive words.
// Head entry is always visible on rdata; a full FIFO accepts a push alongside a pop.
module ddr_rx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_rx_deser.sv
// DDR receive deserializer: dual-edge capture, training-word alignment,
// and a show-ahead FIFO feeding a valid/ready word stream.
module ddr_rx_deser
    import ddr_rx_pkg::*;
#(
    parameter int                      DATA_WIDTH = 8,
    parameter logic [2*DATA_WIDTH-1:0] TRAIN_WORD = 16'h5AC3,
    parameter int                      LOCK_COUNT = 4,
    parameter int                      FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   ddr_in,
    input  logic                    relock,
    output logic [2*DATA_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    locked,
    output logic                    phase,
    output logic                    overflow
);

    localparam int             WW       = 2 * DATA_WIDTH;
    localparam int             CW       = cnt_width(LOCK_COUNT);
    localparam logic [CW-1:0]  LOCK_CNT = CW'(LOCK_COUNT);

    logic [DATA_WIDTH-1:0] pos_r;
    logic [DATA_WIDTH-1:0] neg_r;
    logic [WW-1:0]         cand0;
    logic [WW-1:0]         cand1;
    logic [WW-1:0]         sel;
    logic                  sel_train;

    ddr_rx_state_t state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          phase_r;
    logic          overflow_r;

    logic          push_req;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_r <= '0;
        end else begin
            pos_r <= ddr_in;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            neg_r <= '0;
        end else begin
            neg_r <= ddr_in;
        end
    end

    // cand1 reaches the posedge flops from neg_r in half a cycle
    assign cand0     = {neg_r, pos_r};
    assign cand1     = {ddr_in, neg_r};
    assign sel       = phase_r ? cand1 : cand0;
    assign sel_train = (sel == TRAIN_WORD);
    assign cnt_inc   = cnt + 1'b1;

    assign push_req = (state == LOCKED) && !sel_train && !relock;
    assign pop      = m_valid && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            cnt        <= '0;
            phase_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else if (relock) begin
            state      <= HUNT;
            cnt        <= '0;
            overflow_r <= 1'b0;
        end else begin
            unique case (state)
                HUNT: begin
                    if (cand0 == TRAIN_WORD || cand1 == TRAIN_WORD) begin
                        phase_r <= (cand0 != TRAIN_WORD);
                        cnt     <= CW'(1);
                        state   <= (LOCK_COUNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (sel_train) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == LOCK_CNT) begin
                            state <= LOCKED;
                        end
                    end else begin
                        cnt   <= '0;
                        state <= HUNT;
                    end
                end
                LOCKED: begin
                    if (push_req && fifo_full && !pop) begin
                        overflow_r <= 1'b1;
                    end
                end
                default: begin
                    state <= HUNT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    ddr_rx_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (relock),
        .push  (push_req),
        .wdata (sel),
        .pop   (pop),
        .rdata (m_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid  = !fifo_empty;
    assign locked   = (state == LOCKED);
    assign phase    = phase_r;
    assign overflow = overflow_r;

endmodule
